// File: rtl/row_vector_feeder.sv
// row_vector_feeder: streams matrix-row and vector chunks to a row-by-vector engine,
// paces rows on the engine's row-complete request and collects one indexed result per row.
module row_vector_feeder #(
  parameter int NI            = 8,
  parameter int element_width = 32,
  parameter int ADDR_W        = 10,
  parameter int ROW_W         = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ROW_W-1:0]            num_rows,
  input  logic [31:0]                 multiples_per_row,
  input  logic [ADDR_W-1:0]           a_base,
  output logic                        busy,
  output logic                        done,
  output logic                        mem_a_rd_en,
  output logic [ADDR_W-1:0]           mem_a_rd_addr,
  input  logic [NI*element_width-1:0] mem_a_rd_data,
  output logic                        mem_p_rd_en,
  output logic [ADDR_W-1:0]           mem_p_rd_addr,
  input  logic [NI*element_width-1:0] mem_p_rd_data,
  output logic [NI*element_width-1:0] a,
  output logic [NI*element_width-1:0] p,
  output logic [31:0]                 no_of_multiples,
  output logic                        start_row_by_vector,
  output logic                        you_can_read,
  input  logic                        I_am_ready,
  input  logic                        give_me_only,
  input  logic                        decoder_read_now,
  input  logic [element_width-1:0]    result,
  output logic                        res_valid,
  output logic [element_width-1:0]    res_data,
  output logic [ROW_W-1:0]            res_index
);
  localparam int DW = NI * element_width;

  typedef enum logic [2:0] {IDLE, WAIT_RDY, FETCH, LOAD, PRESENT, WAIT_ROW, DRAIN, DONE} state_t;

  state_t              r_state, w_next;
  logic [ROW_W-1:0]    r_rows, r_row, r_res_cnt, r_res_index;
  logic [31:0]         r_m, r_k;
  logic [ADDR_W-1:0]   r_row_addr;
  logic [DW-1:0]       r_a, r_p;
  logic [element_width-1:0] r_res_data;
  logic                r_pend, r_res_valid;
  logic                w_busy, w_last_k, w_row_go, w_last_row;

  assign w_busy     = (r_state != IDLE) && (r_state != DONE);
  assign w_last_k   = r_k == r_m - 32'd1;
  assign w_row_go   = give_me_only || r_pend;
  assign w_last_row = (r_row + ROW_W'(1)) == r_rows;

  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (start) w_next = (num_rows == '0) ? DONE : WAIT_RDY;
      WAIT_RDY: if (I_am_ready) w_next = FETCH;
      FETCH:    w_next = LOAD;
      LOAD:     w_next = PRESENT;
      PRESENT:  w_next = w_last_k ? WAIT_ROW : WAIT_RDY;
      WAIT_ROW: if (w_row_go) w_next = w_last_row ? DRAIN : WAIT_RDY;
      DRAIN:    if (r_res_cnt == r_rows) w_next = DONE;
      DONE:     w_next = IDLE;
    endcase
  end

  // r_row_addr tracks a_base + r*M modulo the address space, so no multiplier is needed
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rows      <= '0;
      r_row       <= '0;
      r_res_cnt   <= '0;
      r_m         <= '0;
      r_k         <= '0;
      r_row_addr  <= '0;
      r_a         <= '0;
      r_p         <= '0;
      r_pend      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_index <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_rows     <= num_rows;
        r_m        <= (multiples_per_row == '0) ? 32'd1 : multiples_per_row;
        r_row_addr <= a_base;
        r_row      <= '0;
        r_k        <= '0;
        r_res_cnt  <= '0;
      end
      if (r_state == LOAD) begin
        r_a <= mem_a_rd_data;
        r_p <= mem_p_rd_data;
      end
      if (r_state == PRESENT) r_k <= w_last_k ? '0 : r_k + 32'd1;
      if (r_state == WAIT_ROW && w_row_go) begin
        r_row      <= r_row + ROW_W'(1);
        r_row_addr <= r_row_addr + r_m[ADDR_W-1:0];
      end
      // an early row request is remembered until WAIT_ROW consumes it
      r_pend      <= w_busy && (r_state != WAIT_ROW) && (r_pend || give_me_only);
      r_res_valid <= w_busy && decoder_read_now;
      if (w_busy && decoder_read_now) begin
        r_res_data  <= result;
        r_res_index <= r_res_cnt;
        r_res_cnt   <= r_res_cnt + ROW_W'(1);
      end
    end
  end

  assign busy                = w_busy;
  assign done                = r_state == DONE;
  assign mem_a_rd_en         = r_state == FETCH;
  assign mem_p_rd_en         = r_state == FETCH;
  assign mem_a_rd_addr       = mem_a_rd_en ? r_row_addr + r_k[ADDR_W-1:0] : '0;
  assign mem_p_rd_addr       = mem_p_rd_en ? r_k[ADDR_W-1:0] : '0;
  assign a                   = r_a;
  assign p                   = r_p;
  assign no_of_multiples     = r_m;
  assign you_can_read        = r_state == PRESENT;
  assign start_row_by_vector = (r_state == PRESENT) && (r_k == '0);
  assign res_valid           = r_res_valid;
  assign res_data            = r_res_data;
  assign res_index           = r_res_index;
endmodule
